// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer: one prescaled sample tick, per-channel synchroniser and stability counter.
// Optional auto-repeat pulses are built in when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_multi #(
    parameter int NUM_CH       = 5,
    parameter int PRESCALE     = 65536,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_rep,
    output logic              tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [PW-1:0]             pre_q, pre_d;
    logic                      tick_q, tick_d;
    logic [NUM_CH-1:0]         sync1_q, sync2_q;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]         level_q, level_d;
    logic [NUM_CH-1:0]         rise_q, rise_d;
    logic [NUM_CH-1:0]         fall_q, fall_d;

    // tick is high in the cycle after the counter wraps, so it lands on every PRESCALE-th cycle
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        tick_d = (pre_q == PRE_LAST);
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign tick      = tick_q;
    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_DELAY_V = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE_V  = RW'(REPEAT_RATE);

    logic [NUM_CH-1:0][RW-1:0] rcnt_q, rcnt_d;
    logic [NUM_CH-1:0]         armed_q, armed_d;
    logic [NUM_CH-1:0]         rep_q, rep_d;
    logic [RW-1:0]             rnext;

    // armed marks that the initial delay has elapsed; afterwards the counter restarts every REPEAT_RATE ticks
    always_comb begin
        rcnt_d  = rcnt_q;
        armed_d = armed_q;
        rep_d   = '0;
        rnext   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!level_d[i] || rise_d[i]) begin
                rcnt_d[i]  = '0;
                armed_d[i] = 1'b0;
            end else if (tick_q) begin
                rnext = rcnt_q[i] + RW'(1);
                if ((!armed_q[i] && rnext == REP_DELAY_V) || (armed_q[i] && rnext == REP_RATE_V)) begin
                    rep_d[i]   = 1'b1;
                    armed_d[i] = 1'b1;
                    rcnt_d[i]  = '0;
                end else begin
                    rcnt_d[i] = rnext;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q  <= '0;
            armed_q <= '0;
            rep_q   <= '0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
        end
    end

    assign btn_rep = rep_q;
`else
    // Repeat timing only matters when the feature is built in.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign btn_rep        = '0;
`endif

endmodule
